// File: rtl/video_mode_seq.sv
// Test-pattern mode sequencer: Wishbone register file plus a MANUAL/PENDING/AUTO FSM.
// Mode changes happen only on frame boundaries, taken from the falling edge of the synchronized vsync.
module video_mode_seq #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DWELL_RST   = 16'd60
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_wb_cyc,
  input  logic        I_wb_stb,
  input  logic        I_wb_we,
  input  logic [1:0]  I_wb_adr,
  input  logic [31:0] I_wb_dat,
  output logic [31:0] O_wb_dat,
  output logic        O_wb_ack,
  input  logic        I_vs,
  output logic [1:0]  O_pattern_mode,
  output logic        O_irq
);

  typedef enum logic [1:0] {ST_MANUAL, ST_PENDING, ST_AUTO} state_e;

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_DWELL  = 2'd1;
  localparam logic [1:0] ADR_STATUS = 2'd2;
  localparam logic [1:0] ADR_IRQ    = 2'd3;

  logic [SYNC_STAGES-1:0] vs_sync_q;
  logic                   vs_prev_q;
  logic                   fb;

  logic        ack_q;
  logic [31:0] rdat_q, rdat_d;
  logic [1:0]  req_mode_q;
  logic        auto_en_q, freeze_q, irq_en_q;
  logic [15:0] dwell_q, frame_cnt_q, dwell_cnt_q;
  logic        irq_flag_q;
  logic [1:0]  mode_q;
  state_e      state_q;

  logic        wb_req, wb_commit, ctrl_wr, dwell_wr, irq_wr;
  state_e      state_fb;
  logic [1:0]  mode_fb;
  logic [15:0] cnt_fb, dwell_lim;
  logic [16:0] cnt_inc;
  logic        unused_wdat;

  assign fb        = vs_prev_q & ~vs_sync_q[SYNC_STAGES-1];
  assign wb_req    = I_wb_cyc & I_wb_stb;
  // Writes land at the edge that ends the ack cycle, so a reset during ack discards them.
  assign wb_commit = wb_req & I_wb_we & ack_q;
  assign ctrl_wr   = wb_commit && (I_wb_adr == ADR_CTRL);
  assign dwell_wr  = wb_commit && (I_wb_adr == ADR_DWELL);
  assign irq_wr    = wb_commit && (I_wb_adr == ADR_IRQ);

  assign unused_wdat = ^{I_wb_dat[31:16], I_wb_dat[7:2]};

  assign O_wb_ack       = ack_q;
  assign O_wb_dat       = rdat_q;
  assign O_pattern_mode = mode_q;
  assign O_irq          = irq_flag_q & irq_en_q;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      vs_sync_q <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], I_vs};
      vs_prev_q <= vs_sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rdat_d = '0;
    case (I_wb_adr)
      ADR_CTRL:   rdat_d = {21'd0, irq_en_q, freeze_q, auto_en_q, 6'd0, req_mode_q};
      ADR_DWELL:  rdat_d = {16'd0, dwell_q};
      ADR_STATUS: rdat_d = {frame_cnt_q, 7'd0, (state_q == ST_PENDING), 6'd0, mode_q};
      default:    rdat_d = {31'd0, irq_flag_q};
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      req_mode_q  <= '0;
      auto_en_q   <= 1'b0;
      freeze_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      dwell_q     <= DWELL_RST;
      frame_cnt_q <= '0;
      irq_flag_q  <= 1'b0;
    end else begin
      ack_q       <= wb_req & ~ack_q;
      rdat_q      <= (wb_req && !ack_q && !I_wb_we) ? rdat_d : '0;
      frame_cnt_q <= frame_cnt_q + {15'd0, fb};
      // A boundary wins over a simultaneous write-1-to-clear.
      irq_flag_q  <= fb | (irq_flag_q & ~(irq_wr & I_wb_dat[0]));
      if (ctrl_wr) begin
        req_mode_q <= I_wb_dat[1:0];
        auto_en_q  <= I_wb_dat[8];
        freeze_q   <= I_wb_dat[9];
        irq_en_q   <= I_wb_dat[10];
      end
      if (dwell_wr) dwell_q <= I_wb_dat[15:0];
    end
  end

  // Frame-boundary step evaluated on pre-write register values.
  always_comb begin
    state_fb  = state_q;
    mode_fb   = mode_q;
    cnt_fb    = dwell_cnt_q;
    dwell_lim = (dwell_q == 16'd0) ? 16'd1 : dwell_q;
    cnt_inc   = {1'b0, dwell_cnt_q} + 17'd1;
    if (fb && !freeze_q) begin
      case (state_q)
        ST_PENDING: begin
          mode_fb  = req_mode_q;
          state_fb = ST_MANUAL;
        end
        ST_AUTO: begin
          if (cnt_inc >= {1'b0, dwell_lim}) begin
            mode_fb = mode_q + 2'd1;
            cnt_fb  = '0;
          end else begin
            cnt_fb = cnt_inc[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_MANUAL;
      mode_q      <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_fb;
      mode_q      <= mode_fb;
      dwell_cnt_q <= cnt_fb;
      if (ctrl_wr) begin
        if (I_wb_dat[8]) begin
          if (state_fb != ST_AUTO) begin
            state_q     <= ST_AUTO;
            dwell_cnt_q <= '0;
          end
        end else if (state_fb == ST_AUTO || I_wb_dat[1:0] != mode_fb) begin
          state_q <= ST_PENDING;
        end
      end
    end
  end

endmodule

// File: doc/video_mode_seq.md
VIDEO_MODE_SEQ -- requirements
Module: video_mode_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops synchronizing I_vs into the I_clk domain (legal range 2-4).
REQ-002 SHALL have parameter DWELL_RST, default 16'd60, reset value of the DWELL register.
REQ-003 SHALL have port I_clk, input, 1, system/Wishbone clock (27 MHz).
REQ-004 SHALL have port I_rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports I_wb_cyc, I_wb_stb, I_wb_we, inputs, 1 each, Wishbone classic cycle/strobe/write.
REQ-006 SHALL have ports I_wb_adr (input, 2, word address), I_wb_dat (input, 32, write data), O_wb_dat (output, 32, read data), O_wb_ack (output, 1, acknowledge).
REQ-007 SHALL have port I_vs, input, 1, active-high vertical sync from the pixel-clock domain (asynchronous to I_clk).
REQ-008 SHALL have port O_pattern_mode, output, 2, pattern select driven to the test-pattern generator.
REQ-009 SHALL have port O_irq, output, 1, level interrupt, frame-boundary flag AND irq enable.

Function
REQ-010 SHALL synchronize I_vs through SYNC_STAGES flops and define a frame boundary (FB) as a one-cycle pulse on the synchronized 1->0 transition.
REQ-011 SHALL implement registers: 0 CTRL (RW: [1:0] req_mode, [8] auto_en, [9] freeze, [10] irq_en); 1 DWELL (RW [15:0]); 2 STATUS (RO: [1:0] active mode, [8] pending, [31:16] frame_cnt); 3 IRQ (bit 0 flag, write-1-to-clear).
REQ-012 SHALL assert O_wb_ack one cycle after cyc&stb with ack low, hold it one cycle, then deassert; a held strobe yields ack every second cycle.
REQ-013 SHALL perform writes on the cycle ack is asserted; unused bits read 0; writes to STATUS ignored.
REQ-014 SHALL implement FSM states MANUAL, PENDING, AUTO.
REQ-015 MANUAL: CTRL write with auto_en=0 and req_mode != active mode -> PENDING; with auto_en=1 -> AUTO, dwell counter cleared.
REQ-016 PENDING: on FB with freeze=0, O_pattern_mode <= req_mode, -> MANUAL; STATUS.pending=1 only in this state.
REQ-017 AUTO: dwell counter increments per FB (freeze=0); when counter+1 >= max(DWELL,1), O_pattern_mode <= (mode+1) mod 4 (3 wraps to 0), counter <= 0.
REQ-018 AUTO: CTRL write with auto_en=0 -> PENDING (req_mode applied at next FB); mode never changes except on an FB cycle.
REQ-019 freeze=1 SHALL suppress all mode updates and dwell counting; FB still counts frames and sets the IRQ flag.
REQ-020 frame_cnt SHALL be 16-bit, increment on every FB, wrap 0xFFFF->0.
REQ-021 IRQ flag SHALL set on FB; W1C clear and FB in the same cycle -> flag stays 1.
REQ-022 CTRL write coincident with FB: FB acts on pre-write register values; the write then takes effect (may leave PENDING).
REQ-023 DWELL write in AUTO SHALL not clear the counter; new value compared from the next FB.

Reset
REQ-024 On I_rst_n low, asynchronously: O_pattern_mode=0, O_wb_ack=0, O_wb_dat=0, O_irq=0, state MANUAL, CTRL=0, DWELL=DWELL_RST, frame_cnt=0, dwell counter=0, IRQ flag=0, sync flops=0.
REQ-025 Reset asserted mid-transaction SHALL drop ack immediately; no partial write retained.

Verification
REQ-026 Write CTRL=0x2, then 3 FB pulses -> O_pattern_mode stays 0 until first FB, then 2; STATUS.pending 1 then 0.
REQ-027 CTRL=0x100, DWELL=2, 9 FBs -> mode sequence 0,0,1,1,2,2,3,3,0 (wrap).
REQ-028 DWELL=0 in AUTO -> mode advances on every FB.
REQ-029 CTRL=0x200|0x1 then 5 FBs -> mode stays 0, frame_cnt=5; clear freeze -> mode 1 at next FB.
REQ-030 irq_en=1, FB coincident with IRQ W1C -> O_irq remains 1; separate W1C -> O_irq 0 next cycle.
REQ-031 Assert I_rst_n low during AUTO with pending ack -> all outputs 0 within the same cycle, DWELL reads DWELL_RST after release.
